// File: rtl/cmd_script_player_pkg.sv
// Shared types and constants for the command script player.
package cmd_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RESP  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_script_player_if.sv
// Link between the script player and the remote-comm transmitter/receiver.
interface cmd_script_player_if #(
  parameter int CMD_W = 16
) ();
  logic             send_cmd;
  logic [CMD_W-1:0] cmd;
  logic             resp_rdy;
  logic [7:0]       resp;

  modport master (output send_cmd, output cmd, input resp_rdy, input resp);
  modport slave  (input send_cmd, input cmd, output resp_rdy, output resp);
endinterface

// File: rtl/cmd_script_player_fifo.sv
// Command FIFO: power-of-two depth, flush has priority, pushes dropped when full.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int CMD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [CMD_W-1:0]       din,
  output logic [CMD_W-1:0]       dout,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_script_player.sv
// Plays queued commands to the remote link, one at a time, waiting for an ACK byte each.
//   state        | meaning
//   ST_IDLE      | waiting for start; queued commands held
//   ST_SEND      | one-cycle strobe of the FIFO head to the link, head popped
//   ST_WAIT_RESP | waiting for a response byte or the timeout
//   ST_DONE      | script finished cleanly; done pulses next cycle
//   ST_ERROR     | bad response or timeout recorded; back to idle
module cmd_script_player
  import cmd_player_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         CMD_W       = 16,
  parameter int         TIMEOUT_CYC = 2**26,
  parameter logic [7:0] ACK         = ACK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [CMD_W-1:0]       wr_cmd,
  input  logic                   start,
  input  logic                   abort,
  cmd_script_player_if.master    link,
  output logic                   full,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [7:0]             n_acked
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t           state, next_state;
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_hit;
  logic             ack_hit;
  logic             set_err;
  logic             clr_run;
  logic [1:0]       err_code_nxt;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en && !abort),
    .pop   (fifo_pop),
    .flush (abort),
    .din   (wr_cmd),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .full  (full),
    .empty (fifo_empty)
  );

  assign busy          = (state == ST_SEND) || (state == ST_WAIT_RESP);
  assign tmo_hit       = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign link.send_cmd = (state == ST_SEND);
  assign link.cmd      = cmd_q;

  always_comb begin
    next_state   = state;
    fifo_pop     = 1'b0;
    ack_hit      = 1'b0;
    set_err      = 1'b0;
    clr_run      = 1'b0;
    err_code_nxt = ERR_NONE;
    if (abort) begin
      next_state   = ST_IDLE;
      set_err      = 1'b1;
      err_code_nxt = ERR_ABORT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            clr_run    = 1'b1;
            next_state = fifo_empty ? ST_DONE : ST_SEND;
          end
        end
        ST_SEND: begin
          fifo_pop   = 1'b1;
          next_state = ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          // A response landing on the timeout cycle still counts
          if (link.resp_rdy) begin
            if (link.resp == ACK) begin
              ack_hit    = 1'b1;
              next_state = fifo_empty ? ST_DONE : ST_SEND;
            end else begin
              set_err      = 1'b1;
              err_code_nxt = ERR_RESP;
              next_state   = ST_ERROR;
            end
          end else if (tmo_hit) begin
            set_err      = 1'b1;
            err_code_nxt = ERR_TMO;
            next_state   = ST_ERROR;
          end
        end
        ST_DONE:  next_state = ST_IDLE;
        ST_ERROR: next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      tmo_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      n_acked  <= '0;
    end else begin
      state <= next_state;
      done  <= (state == ST_DONE) && !abort;
      // Counter starts with the send strobe so the timeout is measured from send_cmd
      if (next_state == ST_SEND) begin
        cmd_q   <= fifo_dout;
        tmo_cnt <= '0;
      end else if (busy && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (clr_run) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
        n_acked  <= '0;
      end else if (set_err) begin
        err      <= 1'b1;
        err_code <= err_code_nxt;
      end
      if (ack_hit) n_acked <= sat_inc8(n_acked);
    end
  end

endmodule

// File: tb/tb_cmd_script_player.sv
// Bench for cmd_script_player with a remote-comm model answering 20 cycles after each send.
module tb_cmd_script_player;
  import cmd_player_pkg::*;

  localparam int DEPTH    = 8;
  localparam int CMD_W    = 16;
  localparam int TMO      = 1000;
  localparam int RESP_DLY = 20;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   wr_en = 1'b0;
  logic [CMD_W-1:0]       wr_cmd = '0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   full, busy, done, err;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [1:0]             err_code;
  logic [7:0]             n_acked;

  cmd_script_player_if #(.CMD_W(CMD_W)) link ();

  cmd_script_player #(
    .DEPTH       (DEPTH),
    .CMD_W       (CMD_W),
    .TIMEOUT_CYC (TMO),
    .ACK         (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .start    (start),
    .abort    (abort),
    .link     (link),
    .full     (full),
    .fifo_cnt (fifo_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .n_acked  (n_acked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_count = 0;
  int resp_mode = 0;  // 0 ack, 1 nak (0x5A), 2 silent
  int rd_idx = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic [CMD_W-1:0] obs_q[$];
  int               obs_cyc_q[$];
  logic [CMD_W-1:0] exp_c;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every send strobe and done pulse
  always @(negedge clk) begin
    if (link.send_cmd === 1'b1) begin
      obs_q.push_back(link.cmd);
      obs_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_count++;
  end

  // Remote-comm model
  initial begin : responder
    int resp_cd;
    resp_cd = 0;
    link.resp_rdy = 1'b0;
    link.resp = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      link.resp_rdy = 1'b0;
      if (!rst_n) begin
        resp_cd = 0;
      end else if (link.send_cmd === 1'b1) begin
        if (resp_mode != 2) resp_cd = RESP_DLY;
      end else if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          link.resp_rdy = 1'b1;
          link.resp = (resp_mode == 1) ? 8'h5A : 8'hA5;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [CMD_W-1:0] c, input bit accept);
    wr_en = 1'b1;
    wr_cmd = c;
    tick();
    wr_en = 1'b0;
    if (accept) exp_q.push_back(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL reset_fifo_cnt: got %0d expected 0", fifo_cnt); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_checks++; if (link.send_cmd !== 1'b0) $display("FAIL reset_send: got %b expected 0", link.send_cmd); else n_pass++;
    n_checks++; if (link.cmd !== 16'h0000) $display("FAIL reset_cmd: got %h expected 0000", link.cmd); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); else n_pass++;
    n_checks++; if (err_code !== ERR_NONE) $display("FAIL reset_err_code: got %b expected 00", err_code); else n_pass++;
    n_checks++; if (n_acked !== 8'd0) $display("FAIL reset_n_acked: got %0d expected 0", n_acked); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_script();
    int base_s, base_d;
    resp_mode = 0;
    base_s = obs_q.size();
    base_d = done_count;
    push_cmd(16'h0000, 1'b1);
    push_cmd(16'h4000, 1'b1);
    push_cmd(16'h2000, 1'b1);
    pulse_start();
    repeat (120) tick();
    n_checks++; if (obs_q.size() - base_s !== 3) $display("FAIL script_sends: got %0d expected 3", obs_q.size() - base_s); else n_pass++;
    while (rd_idx < obs_q.size()) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL script_order: got extra cmd %h expected none", obs_q[rd_idx]);
      end else begin
        exp_c = exp_q.pop_front();
        if (obs_q[rd_idx] !== exp_c) $display("FAIL script_order: got %h expected %h", obs_q[rd_idx], exp_c); else n_pass++;
      end
      rd_idx++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL script_missing: got %0d unsent expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (n_acked !== 8'd3) $display("FAIL script_n_acked: got %0d expected 3", n_acked); else n_pass++;
    n_checks++; if (done_count - base_d !== 1) $display("FAIL script_done: got %0d pulses expected 1", done_count - base_d); else n_pass++;
    n_checks++; if ({err, busy} !== 2'b00) $display("FAIL script_err_busy: got %b expected 00", {err, busy}); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_bad_resp();
    int base_s;
    resp_mode = 1;
    base_s = obs_q.size();
    push_cmd(16'h4000, 1'b0);
    push_cmd(16'h2C00, 1'b0);
    pulse_start();
    repeat (60) tick();
    n_checks++; if (obs_q.size() - base_s !== 1) $display("FAIL nak_sends: got %0d expected 1", obs_q.size() - base_s); else n_pass++;
    n_checks++; if (obs_q.size() > base_s && obs_q[base_s] !== 16'h4000) $display("FAIL nak_cmd: got %h expected 4000", obs_q[base_s]); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL nak_err: got %b expected 1", err); else n_pass++;
    n_checks++; if (err_code !== ERR_RESP) $display("FAIL nak_err_code: got %b expected 01", err_code); else n_pass++;
    n_checks++; if (n_acked !== 8'd0) $display("FAIL nak_n_acked: got %0d expected 0", n_acked); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd1) $display("FAIL nak_fifo_cnt: got %0d expected 1", fifo_cnt); else n_pass++;
    rd_idx = obs_q.size();
    // Abort while idle flushes the leftover and records the abort
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL idle_abort_flush: got %0d expected 0", fifo_cnt); else n_pass++;
    n_checks++; if ({err, err_code} !== {1'b1, ERR_ABORT}) $display("FAIL idle_abort_err: got %b expected 111", {err, err_code}); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int base_s, err_cyc;
    bit seen;
    resp_mode = 2;
    base_s = obs_q.size();
    seen = 1'b0;
    err_cyc = 0;
    push_cmd(16'h27FF, 1'b0);
    pulse_start();
    for (int i = 0; i < 1200 && !seen; i++) begin
      tick();
      if (err === 1'b1) begin
        seen = 1'b1;
        err_cyc = cyc;
      end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL tmo_wait: got no err within 1200 cycles expected err");
    end else if (obs_q.size() == base_s) begin
      $display("FAIL tmo_latency: got no send_cmd expected one");
    end else if (err_cyc - obs_cyc_q[base_s] !== TMO) begin
      $display("FAIL tmo_latency: got %0d cycles expected %0d", err_cyc - obs_cyc_q[base_s], TMO);
    end else n_pass++;
    n_checks++; if (err_code !== ERR_TMO) $display("FAIL tmo_err_code: got %b expected 10", err_code); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL tmo_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (obs_q.size() - base_s !== 1) $display("FAIL tmo_sends: got %0d expected 1", obs_q.size() - base_s); else n_pass++;
    rd_idx = obs_q.size();
    tick();
  endtask

  task automatic test_full();
    int base_s, base_d;
    resp_mode = 0;
    base_s = obs_q.size();
    base_d = done_count;
    for (int i = 0; i < DEPTH; i++) push_cmd(CMD_W'(16'h0100 + i), 1'b1);
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag: got %b expected 1", full); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'(DEPTH)) $display("FAIL full_cnt: got %0d expected %0d", fifo_cnt, DEPTH); else n_pass++;
    push_cmd(16'hDEAD, 1'b0);
    push_cmd(16'hBEEF, 1'b0);
    n_checks++; if (fifo_cnt !== 4'(DEPTH)) $display("FAIL full_drop: got %0d expected %0d", fifo_cnt, DEPTH); else n_pass++;
    pulse_start();
    n_checks++; if (err !== 1'b0) $display("FAIL start_clears_err: got %b expected 0", err); else n_pass++;
    repeat (DEPTH * (RESP_DLY + 2) + 20) tick();
    n_checks++; if (obs_q.size() - base_s !== DEPTH) $display("FAIL full_sends: got %0d expected %0d", obs_q.size() - base_s, DEPTH); else n_pass++;
    while (rd_idx < obs_q.size()) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL full_order: got extra cmd %h expected none", obs_q[rd_idx]);
      end else begin
        exp_c = exp_q.pop_front();
        if (obs_q[rd_idx] !== exp_c) $display("FAIL full_order: got %h expected %h", obs_q[rd_idx], exp_c); else n_pass++;
      end
      rd_idx++;
    end
    n_checks++; if (n_acked !== 8'(DEPTH)) $display("FAIL full_n_acked: got %0d expected %0d", n_acked, DEPTH); else n_pass++;
    n_checks++; if (done_count - base_d !== 1) $display("FAIL full_done: got %0d pulses expected 1", done_count - base_d); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_abort();
    int base_s;
    bit reached;
    resp_mode = 0;
    base_s = obs_q.size();
    reached = 1'b0;
    push_cmd(16'h1111, 1'b1);
    push_cmd(16'h2222, 1'b1);
    push_cmd(16'h3333, 1'b1);
    push_cmd(16'h4444, 1'b1);
    pulse_start();
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      if (obs_q.size() - base_s >= 2) reached = 1'b1;
    end
    n_checks++; if (!reached) $display("FAIL abort_wait: got %0d sends expected 2", obs_q.size() - base_s); else n_pass++;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle: got busy %b expected 0", busy); else n_pass++;
    n_checks++; if (fifo_cnt !== 4'd0) $display("FAIL abort_flush: got %0d expected 0", fifo_cnt); else n_pass++;
    n_checks++; if ({err, err_code} !== {1'b1, ERR_ABORT}) $display("FAIL abort_err: got %b expected 111", {err, err_code}); else n_pass++;
    repeat (40) tick();
    n_checks++; if (obs_q.size() - base_s !== 2) $display("FAIL abort_no_send: got %0d sends expected 2", obs_q.size() - base_s); else n_pass++;
    n_checks++; if (n_acked !== 8'd1) $display("FAIL abort_late_resp: got n_acked %0d expected 1", n_acked); else n_pass++;
    n_checks++; if (err_code !== ERR_ABORT) $display("FAIL abort_sticky: got %b expected 11", err_code); else n_pass++;
    while (rd_idx < obs_q.size()) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL abort_order: got extra cmd %h expected none", obs_q[rd_idx]);
      end else begin
        exp_c = exp_q.pop_front();
        if (obs_q[rd_idx] !== exp_c) $display("FAIL abort_order: got %h expected %h", obs_q[rd_idx], exp_c); else n_pass++;
      end
      rd_idx++;
    end
    n_checks++; if (exp_q.size() != 2) $display("FAIL abort_unsent: got %0d expected 2", exp_q.size()); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_empty_start();
    int base_s;
    base_s = obs_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0) $display("FAIL empty_done_early: got %b expected 0", done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL empty_done: got %b expected 1", done); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL empty_done_width: got %b expected 0", done); else n_pass++;
    n_checks++; if ({err, err_code} !== 3'b000) $display("FAIL empty_err_clear: got %b expected 000", {err, err_code}); else n_pass++;
    n_checks++; if (obs_q.size() != base_s) $display("FAIL empty_no_send: got %0d sends expected 0", obs_q.size() - base_s); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base_d;
    resp_mode = 0;
    push_cmd(16'h5555, 1'b0);
    pulse_start();
    repeat (5) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else n_pass++;
    base_d = done_count;
    rst_n = 1'b0;
    #1;
    n_checks++; if (link.cmd !== 16'h0000) $display("FAIL mid_rst_cmd: got %h expected 0000", link.cmd); else n_pass++;
    n_checks++; if ({busy, done, err, link.send_cmd} !== 4'b0000) $display("FAIL mid_rst_flags: got %b expected 0000", {busy, done, err, link.send_cmd}); else n_pass++;
    n_checks++; if ({fifo_cnt, full, err_code, n_acked} !== 15'd0) $display("FAIL mid_rst_state: got %h expected 0", {fifo_cnt, full, err_code, n_acked}); else n_pass++;
    repeat (30) tick();
    n_checks++; if (done_count != base_d || err !== 1'b0) $display("FAIL mid_rst_silent: got done %0d err %b expected 0 0", done_count - base_d, err); else n_pass++;
    rst_n = 1'b1;
    tick();
    rd_idx = obs_q.size();
  endtask

  initial begin
    test_reset();
    test_script();
    test_bad_resp();
    test_timeout();
    test_full();
    test_abort();
    test_empty_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
